// File: rtl/serial_pkg.sv
// ============================================================================
//  serial_pkg : framing constants, FSM states and length clamp shared by the
//               serial pattern transmitter and the detectors it feeds.
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam int WIDTH = 10;
  localparam int LEN_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_pattern_tx_if.sv
// ============================================================================
//  serial_pattern_tx_if : word-offer handshake plus serial bit stream.
//  Revision             : 1.0
// ============================================================================
`default_nettype none

interface serial_pattern_tx_if;
  import serial_pkg::*;

  logic             load;
  logic [WIDTH-1:0] word;
  logic [LEN_W-1:0] len;
  logic             ready;
  logic             o;
  logic             valid;
  logic             last;

  modport master (output load, word, len, input ready, o, valid, last);
  modport slave  (input load, word, len, output ready, o, valid, last);

endinterface

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
//  serial_pattern_tx : MSB-first parallel-to-serial transmitter with a
//                      one-entry holding register for gapless word streams.
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module serial_pattern_tx (
  input  logic               clock,
  input  logic               reset_n,
  serial_pattern_tx_if.slave bus
);
  import serial_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_word_q, hold_word_d;
  logic [LEN_W-1:0] hold_len_q, hold_len_d;
  logic             hold_full_q, hold_full_d;
  logic             valid_q, valid_d;
  logic             o_q, o_d;
  logic             last_q, last_d;

  logic [LEN_W-1:0] l_eff;
  logic [WIDTH-1:0] aligned;
  logic             take;

  // Words are left-aligned on entry so the shifter always emits from its MSB.
  assign l_eff   = eff_len(bus.len);
  assign aligned = bus.word << (LEN_W'(WIDTH) - l_eff);
  assign take    = bus.load && !hold_full_q && (l_eff != '0);

  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    cnt_d       = cnt_q;
    hold_word_d = hold_word_q;
    hold_len_d  = hold_len_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          shifter_d = aligned;
          cnt_d     = l_eff;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LEN_W'(1)) begin
          if (hold_full_q) begin
            shifter_d   = hold_word_q;
            cnt_d       = hold_len_q;
            hold_full_d = 1'b0;
          end else if (take) begin
            shifter_d = aligned;
            cnt_d     = l_eff;
          end else begin
            shifter_d = '0;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end else begin
          shifter_d = shifter_q << 1;
          cnt_d     = cnt_q - LEN_W'(1);
          if (take) begin
            hold_word_d = aligned;
            hold_len_d  = l_eff;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        shifter_d = '0;
        cnt_d     = '0;
      end
    endcase

    // Outputs are registered from next-state so they line up with the shifter.
    valid_d = (state_d == SHIFT);
    o_d     = valid_d && shifter_d[WIDTH-1];
    last_d  = valid_d && (cnt_d == LEN_W'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shifter_q   <= '0;
      cnt_q       <= '0;
      hold_word_q <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
      valid_q     <= 1'b0;
      o_q         <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      cnt_q       <= cnt_d;
      hold_word_q <= hold_word_d;
      hold_len_q  <= hold_len_d;
      hold_full_q <= hold_full_d;
      valid_q     <= valid_d;
      o_q         <= o_d;
      last_q      <= last_d;
    end
  end

  assign bus.ready = !hold_full_q;
  assign bus.o     = o_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
//  tb_serial_pattern_tx : scoreboard bench for serial_pattern_tx.
//  Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_serial_pattern_tx;
  import serial_pkg::*;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   words_pending;
  exp_t q[$];

  serial_pattern_tx_if bus ();

  serial_pattern_tx dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word contributes min(len,WIDTH) bits, MSB of that slice first.
  task automatic push_model(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] l);
    int n;
    n = (int'(l) > WIDTH) ? WIDTH : int'(l);
    for (int i = n - 1; i >= 0; i--) q.push_back('{b: w[i], last: (i == 0)});
    if (n > 0) words_pending++;
  endtask

  task automatic offer(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] l);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    @(negedge clk);
    bus.load = 1'b1;
    bus.word = w;
    bus.len  = l;
    while (!acc) begin
      acc = bus.ready;
      @(posedge clk);
      if (acc) begin
        push_model(w, l);
      end else begin
        waited++;
        if (waited > 64) begin
          chk("accept_timeout", 32'd0, 32'd1);
          break;
        end
        @(negedge clk);
      end
    end
    #1;
    bus.load = 1'b0;
    bus.word = WIDTH'($urandom);
    bus.len  = LEN_W'($urandom);
  endtask

  // Monitor: pending bits must stream with no bubble; ready drops only while a
  // second accepted word waits behind the one being sent.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("ready", 32'(bus.ready), 32'(words_pending <= 1));
      chk("valid", 32'(bus.valid), 32'(q.size() != 0));
      if (bus.valid) begin
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("o", 32'(bus.o), 32'(e.b));
          chk("last", 32'(bus.last), 32'(e.last));
          if (e.last) words_pending--;
        end
      end else begin
        chk("o_idle", 32'(bus.o), 32'd0);
        chk("last_idle", 32'(bus.last), 32'd0);
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    words_pending = 0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.word      = '0;
    bus.len       = '0;
    #1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_o", 32'(bus.o), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word from idle.
    offer(10'b0110101011, 4'd10);
    drain();

    // Back-to-back: second word is held, stream stays contiguous.
    offer(10'b0000000010, 4'd3);
    offer(10'b0000000101, 4'd3);
    drain();

    // Zero-length word is accepted and dropped.
    offer(10'h2AA, 4'd0);
    drain();

    // Over-long length clamps to WIDTH.
    offer(10'h3FF, 4'd15);
    drain();

    // Reset during bit 4 of a word while another word is held.
    offer(10'h2D3, 4'd10);
    offer(10'h1C7, 4'd10);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.valid), 32'd0);
    chk("async_rst_o", 32'(bus.o), 32'd0);
    chk("async_rst_last", 32'(bus.last), 32'd0);
    q.delete();
    words_pending = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized traffic with mixed gaps, lengths and stalls.
    for (int k = 0; k < 80; k++) begin
      offer(WIDTH'($urandom), LEN_W'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
